controlador_cronometro: RTL and testbench

- Sequencer that drives the BCD countdown timer (units 0-9, tens 0-2) from the initiator side.
- Selects a per-phase preset and pulses the timer's load input.
- Holds the count when the operator pauses.
- Watches the timer's zero and 15-second flags, then advances a three-phase cycle (A -> B -> C -> A) and reports phase, warning and expiry to the top level.

---
 rtl/controlador_cronometro_pkg.sv | 32 +++
 rtl/seletor_preset.sv | 47 ++++
 rtl/controlador_cronometro.sv | 92 +++++++++
 tb/tb_controlador_cronometro.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_cronometro_pkg.sv
// Shared definitions for the countdown-timer sequencer: FSM states, phase codes
// and the BCD limits that preset parameters are checked against.
package controlador_cronometro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSED,
        EXPIRE
    } estado_t;

    localparam logic [1:0] FASE_A = 2'd0;
    localparam logic [1:0] FASE_B = 2'd1;
    localparam logic [1:0] FASE_C = 2'd2;

    localparam logic [3:0] UNID_MAX = 4'd9;
    localparam logic [1:0] DEZ_MAX  = 2'd2;

    function automatic logic preset_valido(input logic [7:0] p);
        return (p[7:6] == 2'b00) && (p[5:4] <= DEZ_MAX) && (p[3:0] <= UNID_MAX);
    endfunction

    function automatic logic [1:0] proxima_fase(input logic [1:0] f);
        case (f)
            FASE_A:  return FASE_B;
            FASE_B:  return FASE_C;
            default: return FASE_A;
        endcase
    endfunction

endpackage

// File: rtl/seletor_preset.sv
// Phase -> BCD preset decode for the timer; illegal presets stop elaboration.
module seletor_preset
    import controlador_cronometro_pkg::*;
#(
    parameter logic [7:0] PRESET_A = 8'h25,
    parameter logic [7:0] PRESET_B = 8'h05,
    parameter logic [7:0] PRESET_C = 8'h20
) (
    input  logic [1:0] fase,
    output logic [3:0] unid_preset,
    output logic [1:0] dez_preset
);

    if (!preset_valido(PRESET_A)) begin : g_preset_a_invalido
        $error("PRESET_A is not a legal BCD preset (tens 0-2, units 0-9)");
    end
    if (!preset_valido(PRESET_B)) begin : g_preset_b_invalido
        $error("PRESET_B is not a legal BCD preset (tens 0-2, units 0-9)");
    end
    if (!preset_valido(PRESET_C)) begin : g_preset_c_invalido
        $error("PRESET_C is not a legal BCD preset (tens 0-2, units 0-9)");
    end

    localparam logic [3:0] UNID_A = PRESET_A[3:0];
    localparam logic [1:0] DEZ_A  = PRESET_A[5:4];
    localparam logic [3:0] UNID_B = PRESET_B[3:0];
    localparam logic [1:0] DEZ_B  = PRESET_B[5:4];
    localparam logic [3:0] UNID_C = PRESET_C[3:0];
    localparam logic [1:0] DEZ_C  = PRESET_C[5:4];

    always_comb begin
        unid_preset = UNID_A;
        dez_preset  = DEZ_A;
        case (fase)
            FASE_B: begin
                unid_preset = UNID_B;
                dez_preset  = DEZ_B;
            end
            FASE_C: begin
                unid_preset = UNID_C;
                dez_preset  = DEZ_C;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/controlador_cronometro.sv
// Initiator-side sequencer for the BCD countdown timer: loads a per-phase preset,
// handles pause/resume and steps the A -> B -> C phase cycle on each expiry.
module controlador_cronometro
    import controlador_cronometro_pkg::*;
#(
    parameter logic [7:0]  PRESET_A    = 8'h25,
    parameter logic [7:0]  PRESET_B    = 8'h05,
    parameter logic [7:0]  PRESET_C    = 8'h20,
    parameter int unsigned EXPIRE_HOLD = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pausa,
    input  logic       sinal,
    input  logic       sinal15,
    output logic       botao,
    output logic       casoEsp,
    output logic [3:0] unid_preset,
    output logic [1:0] dez_preset,
    output logic [1:0] fase,
    output logic       aviso,
    output logic       expirou
);

    if (EXPIRE_HOLD < 1 || EXPIRE_HOLD > 15) begin : g_hold_invalido
        $error("EXPIRE_HOLD must be within 1..15");
    end

    localparam logic [3:0] HOLD_FIM    = 4'(EXPIRE_HOLD);
    localparam logic [3:0] HOLD_AVANCO = HOLD_FIM - 4'd1;

    estado_t    estado, estado_prox;
    logic [3:0] cont_exp;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= IDLE;
            fase     <= FASE_A;
            cont_exp <= '0;
            aviso    <= 1'b0;
            expirou  <= 1'b0;
        end else begin
            estado  <= estado_prox;
            expirou <= (estado == RUN) && sinal && !pausa;
            if (estado == EXPIRE) cont_exp <= cont_exp + 4'd1;
            else                  cont_exp <= '0;
            // Phase steps one cycle before LOAD so the presets settle ahead of botao.
            if (estado == EXPIRE && cont_exp == HOLD_AVANCO) fase <= proxima_fase(fase);
            if (estado_prox == LOAD)              aviso <= 1'b0;
            else if (estado == RUN && sinal15)    aviso <= 1'b1;
        end
    end

    always_comb begin
        estado_prox = estado;
        botao       = 1'b0;
        casoEsp     = 1'b1;
        case (estado)
            IDLE: begin
                if (start) estado_prox = LOAD;
            end
            LOAD: begin
                botao       = 1'b1;
                estado_prox = RUN;
            end
            RUN: begin
                casoEsp = 1'b0;
                if (pausa)      estado_prox = PAUSED;
                else if (sinal) estado_prox = EXPIRE;
            end
            PAUSED: begin
                if (start && !pausa) estado_prox = RUN;
            end
            EXPIRE: begin
                if (cont_exp == HOLD_FIM) estado_prox = LOAD;
            end
            default: estado_prox = IDLE;
        endcase
    end

    seletor_preset #(
        .PRESET_A(PRESET_A),
        .PRESET_B(PRESET_B),
        .PRESET_C(PRESET_C)
    ) u_seletor (
        .fase       (fase),
        .unid_preset(unid_preset),
        .dez_preset (dez_preset)
    );

endmodule

// File: tb/tb_controlador_cronometro.sv
// Bench for controlador_cronometro: a behavioural countdown timer with randomized
// tick spacing closes the loop, and each scenario task checks the sequencer's outputs.
module tb_controlador_cronometro;

    localparam int HOLD = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pausa = 1'b0;
    logic       sinal, sinal15;
    logic       botao, casoEsp, aviso, expirou;
    logic [3:0] unid_preset;
    logic [1:0] dez_preset, fase;

    int n_checks = 0;
    int n_fail   = 0;

    // Timer model: decimal count, reloaded by botao, decremented on ticks unless held.
    int   count     = 0;
    int   tick_p    = 4;
    int   tick_cnt  = 0;
    logic sinal_frc = 1'b0;
    int   preset_tab [3] = '{25, 5, 20};

    assign sinal   = (count == 0) || sinal_frc;
    assign sinal15 = (count == 15);

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tick_cnt >= tick_p - 1) tick_cnt <= 0;
        else                        tick_cnt <= tick_cnt + 1;
        if (botao)
            count <= int'(dez_preset) * 10 + int'(unid_preset);
        else if (!casoEsp && tick_cnt >= tick_p - 1 && count > 0)
            count <= count - 1;
    end

    controlador_cronometro #(
        .PRESET_A   (8'h25),
        .PRESET_B   (8'h05),
        .PRESET_C   (8'h20),
        .EXPIRE_HOLD(HOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pausa      (pausa),
        .sinal      (sinal),
        .sinal15    (sinal15),
        .botao      (botao),
        .casoEsp    (casoEsp),
        .unid_preset(unid_preset),
        .dez_preset (dez_preset),
        .fase       (fase),
        .aviso      (aviso),
        .expirou    (expirou)
    );

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pausa = 1'b0;
        repeat (3) ciclo();
        n_checks++; if (botao !== 1'b0)      begin n_fail++; $display("FAIL reset_botao: got %b want 0", botao); end
        n_checks++; if (casoEsp !== 1'b1)    begin n_fail++; $display("FAIL reset_casoEsp: got %b want 1", casoEsp); end
        n_checks++; if (aviso !== 1'b0)      begin n_fail++; $display("FAIL reset_aviso: got %b want 0", aviso); end
        n_checks++; if (expirou !== 1'b0)    begin n_fail++; $display("FAIL reset_expirou: got %b want 0", expirou); end
        n_checks++; if (fase !== 2'd0)       begin n_fail++; $display("FAIL reset_fase: got %0d want 0", fase); end
        n_checks++; if (unid_preset !== 4'd5) begin n_fail++; $display("FAIL reset_unid: got %0d want 5", unid_preset); end
        n_checks++; if (dez_preset !== 2'd2) begin n_fail++; $display("FAIL reset_dez: got %0d want 2", dez_preset); end
        reset = 1'b0;
        // Timer reads 00 at power-up, so sinal is high while idle.
        repeat (5) begin
            ciclo();
            n_checks++;
            if (botao !== 1'b0 || expirou !== 1'b0 || casoEsp !== 1'b1) begin
                n_fail++; $display("FAIL idle_ignores_sinal: got botao=%b expirou=%b casoEsp=%b want 0 0 1", botao, expirou, casoEsp);
            end
        end
    endtask

    task automatic test_start_load();
        start = 1'b1;
        ciclo();
        start = 1'b0;
        n_checks++; if (botao !== 1'b1)       begin n_fail++; $display("FAIL load_botao: got %b want 1", botao); end
        n_checks++; if (unid_preset !== 4'd5) begin n_fail++; $display("FAIL load_unid: got %0d want 5", unid_preset); end
        n_checks++; if (dez_preset !== 2'd2)  begin n_fail++; $display("FAIL load_dez: got %0d want 2", dez_preset); end
        n_checks++; if (fase !== 2'd0)        begin n_fail++; $display("FAIL load_fase: got %0d want 0", fase); end
        n_checks++; if (casoEsp !== 1'b1)     begin n_fail++; $display("FAIL load_casoEsp: got %b want 1", casoEsp); end
        ciclo();
        n_checks++; if (botao !== 1'b0)   begin n_fail++; $display("FAIL run_botao: got %b want 0", botao); end
        n_checks++; if (casoEsp !== 1'b0) begin n_fail++; $display("FAIL run_casoEsp: got %b want 0", casoEsp); end
    endtask

    // Starts in a RUN cycle of phase ph; ends in the first RUN cycle of the next phase.
    task automatic finish_phase(input int ph, input logic aviso_ini);
        logic exp_av;
        bit   done;
        int   nx;
        exp_av = aviso_ini;
        done   = 1'b0;
        nx     = (ph + 1) % 3;
        for (int k = 0; k < 3000 && !done; k++) begin
            n_checks++; if (aviso !== exp_av)  begin n_fail++; $display("FAIL run_aviso ph%0d: got %b want %b (count %0d)", ph, aviso, exp_av, count); end
            n_checks++; if (casoEsp !== 1'b0)  begin n_fail++; $display("FAIL run_hold ph%0d: got %b want 0", ph, casoEsp); end
            if (sinal15) exp_av = 1'b1;
            if (sinal) done = 1'b1;
            else       ciclo();
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL phase_timeout ph%0d: got no sinal want sinal within 3000 cycles", ph); end
        ciclo();
        n_checks++; if (expirou !== 1'b1) begin n_fail++; $display("FAIL expirou_pulse ph%0d: got %b want 1", ph, expirou); end
        n_checks++; if (casoEsp !== 1'b1) begin n_fail++; $display("FAIL expire_casoEsp ph%0d: got %b want 1", ph, casoEsp); end
        n_checks++; if (aviso !== logic'(preset_tab[ph] >= 15)) begin
            n_fail++; $display("FAIL aviso_phase ph%0d: got %b want %b", ph, aviso, preset_tab[ph] >= 15);
        end
        for (int i = 0; i < HOLD; i++) begin
            ciclo();
            n_checks++;
            if (botao !== 1'b0 || expirou !== 1'b0) begin
                n_fail++; $display("FAIL expire_wait ph%0d: got botao=%b expirou=%b want 0 0", ph, botao, expirou);
            end
        end
        ciclo();
        n_checks++; if (botao !== 1'b1)      begin n_fail++; $display("FAIL reload_botao ph%0d: got %b want 1", ph, botao); end
        n_checks++; if (fase !== 2'(nx))     begin n_fail++; $display("FAIL reload_fase ph%0d: got %0d want %0d", ph, fase, nx); end
        n_checks++; if (unid_preset !== 4'(preset_tab[nx] % 10)) begin
            n_fail++; $display("FAIL reload_unid ph%0d: got %0d want %0d", ph, unid_preset, preset_tab[nx] % 10);
        end
        n_checks++; if (dez_preset !== 2'(preset_tab[nx] / 10)) begin
            n_fail++; $display("FAIL reload_dez ph%0d: got %0d want %0d", ph, dez_preset, preset_tab[nx] / 10);
        end
        n_checks++; if (aviso !== 1'b0) begin n_fail++; $display("FAIL reload_aviso ph%0d: got %b want 0", ph, aviso); end
        tick_p = int'($urandom_range(3, 6));
        ciclo();
    endtask

    // start stays high throughout: the cycle must keep running and ignore it in RUN.
    task automatic test_full_cycle();
        start = 1'b1;
        for (int ph = 0; ph < 3; ph++) finish_phase(ph, 1'b0);
        start = 1'b0;
    endtask

    task automatic wait_count(input int target);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            if (count == target) hit = 1'b1;
            else                 ciclo();
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL wait_count: got %0d want %0d within 3000 cycles", count, target); end
    endtask

    task automatic test_pause();
        int   saw_botao;
        int   bad_count;
        bit   moved;
        saw_botao = 0;
        bad_count = 0;
        wait_count(18);
        pausa = 1'b1;
        ciclo();
        n_checks++; if (casoEsp !== 1'b1) begin n_fail++; $display("FAIL pause_casoEsp: got %b want 1", casoEsp); end
        repeat (50) begin
            ciclo();
            if (botao !== 1'b0) saw_botao++;
            if (count != 18)    bad_count++;
        end
        n_checks++; if (bad_count != 0) begin n_fail++; $display("FAIL pause_frozen: got %0d cycles off 18 (now %0d) want 0", bad_count, count); end
        n_checks++; if (saw_botao != 0) begin n_fail++; $display("FAIL pause_botao: got %0d pulses want 0", saw_botao); end
        n_checks++; if (aviso !== 1'b0) begin n_fail++; $display("FAIL pause_aviso: got %b want 0", aviso); end
        pausa = 1'b0;
        start = 1'b1;
        ciclo();
        start = 1'b0;
        n_checks++; if (casoEsp !== 1'b0) begin n_fail++; $display("FAIL resume_casoEsp: got %b want 0", casoEsp); end
        n_checks++; if (botao !== 1'b0)   begin n_fail++; $display("FAIL resume_botao: got %b want 0", botao); end
        moved = 1'b0;
        for (int k = 0; k < 20 && !moved; k++) begin
            if (botao !== 1'b0) saw_botao++;
            if (count != 18) moved = 1'b1;
            else             ciclo();
        end
        n_checks++; if (count != 17)    begin n_fail++; $display("FAIL resume_count: got %0d want 17", count); end
        n_checks++; if (saw_botao != 0) begin n_fail++; $display("FAIL resume_no_reload: got %0d pulses want 0", saw_botao); end
    endtask

    task automatic test_sinal_pausa();
        sinal_frc = 1'b1;
        pausa     = 1'b1;
        ciclo();
        sinal_frc = 1'b0;
        n_checks++; if (expirou !== 1'b0) begin n_fail++; $display("FAIL sinal_pausa_expirou: got %b want 0", expirou); end
        n_checks++; if (casoEsp !== 1'b1) begin n_fail++; $display("FAIL sinal_pausa_paused: got %b want 1", casoEsp); end
        ciclo();
        n_checks++; if (expirou !== 1'b0) begin n_fail++; $display("FAIL sinal_pausa_late: got %b want 0", expirou); end
        pausa = 1'b0;
        start = 1'b1;
        ciclo();
        start = 1'b0;
        n_checks++; if (casoEsp !== 1'b0 || expirou !== 1'b0) begin
            n_fail++; $display("FAIL sinal_pausa_resume: got casoEsp=%b expirou=%b want 0 0", casoEsp, expirou);
        end
        finish_phase(0, 1'b0);
        finish_phase(1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int saw_botao;
        saw_botao = 0;
        wait_count(7);
        n_checks++; if (aviso !== 1'b1 || fase !== 2'd2) begin
            n_fail++; $display("FAIL pre_reset: got aviso=%b fase=%0d want 1 2", aviso, fase);
        end
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        n_checks++; if (casoEsp !== 1'b1) begin n_fail++; $display("FAIL midreset_casoEsp: got %b want 1", casoEsp); end
        n_checks++; if (aviso !== 1'b0)   begin n_fail++; $display("FAIL midreset_aviso: got %b want 0", aviso); end
        n_checks++; if (fase !== 2'd0)    begin n_fail++; $display("FAIL midreset_fase: got %0d want 0", fase); end
        n_checks++; if (botao !== 1'b0 || expirou !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pulses: got botao=%b expirou=%b want 0 0", botao, expirou);
        end
        repeat (20) begin
            ciclo();
            if (botao !== 1'b0) saw_botao++;
        end
        n_checks++; if (saw_botao != 0) begin n_fail++; $display("FAIL midreset_no_reload: got %0d pulses want 0", saw_botao); end
        n_checks++; if (count != 7)     begin n_fail++; $display("FAIL midreset_timer_held: got %0d want 7", count); end
        start = 1'b1;
        ciclo();
        start = 1'b0;
        n_checks++; if (botao !== 1'b1 || unid_preset !== 4'd5 || dez_preset !== 2'd2) begin
            n_fail++; $display("FAIL restart_load: got botao=%b preset=%0d%0d want 1 25", botao, dez_preset, unid_preset);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish before 1000000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick_p = int'($urandom_range(3, 6));
        test_reset();
        test_start_load();
        test_full_cycle();
        test_pause();
        test_sinal_pausa();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
